// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the cpu_sequencer controller.
//   state_t   : FSM state encoding
//   instr_t   : instruction class latched when start is accepted
//   OP_*/ALU_*: opcode / ALU_op field values
//   REG_SEL_*/WB_SEL_*: datapath mux select codes
//   decode()  : maps {opcode, ALU_op} to an instruction class
package cpu_seq_pkg;

  typedef enum logic [3:0] {
    S_WAIT, S_MOVI, S_LDA, S_LDB, S_EXEC, S_WB,
    S_ADDR, S_SLDB, S_SEXE, S_MEM, S_LWB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    I_MOVI, I_MOV, I_ADD, I_CMP, I_AND, I_MVN, I_LDR, I_STR, I_HALT, I_ILL
  } instr_t;

  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_ALU  = 3'b101;
  localparam logic [2:0] OP_LDR  = 3'b011;
  localparam logic [2:0] OP_STR  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] MOV_IMM = 2'b10;

  localparam logic [1:0] REG_SEL_RM = 2'b00;
  localparam logic [1:0] REG_SEL_RD = 2'b01;
  localparam logic [1:0] REG_SEL_RN = 2'b10;

  localparam logic [1:0] WB_SEL_C    = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_IMM8 = 2'b10;

  function automatic instr_t decode(input logic [2:0] opcode, input logic [1:0] alu_op);
    instr_t res;
    res = I_ILL;
    case (opcode)
      OP_MOV: begin
        if (alu_op == MOV_IMM)      res = I_MOVI;
        else if (alu_op == MOV_REG) res = I_MOV;
      end
      OP_ALU: begin
        case (alu_op)
          ALU_ADD: res = I_ADD;
          ALU_CMP: res = I_CMP;
          ALU_AND: res = I_AND;
          default: res = I_MVN;
        endcase
      end
      OP_LDR:  if (alu_op == 2'b00) res = I_LDR;
      OP_STR:  if (alu_op == 2'b00) res = I_STR;
      OP_HALT: res = I_HALT;
      default: res = I_ILL;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Bundle of decode inputs, datapath controls and memory handshake for cpu_sequencer.
//   master: the sequencer (drives controls, mem_req/mem_we/mem_err)
//   slave : decode/datapath/memory side (drives start, opcode, ALU_op, mem_ack)
interface cpu_sequencer_if;
  logic       start;
  logic [2:0] opcode;
  logic [1:0] ALU_op;
  logic       mem_ack;
  logic       waiting;
  logic       halted;
  logic [1:0] reg_sel;
  logic [1:0] wb_sel;
  logic       w_en;
  logic       en_A;
  logic       en_B;
  logic       en_C;
  logic       en_status;
  logic       en_addr;
  logic       sel_A;
  logic       sel_B;
  logic       mem_req;
  logic       mem_we;
  logic       mem_err;

  modport master (
    input  start, opcode, ALU_op, mem_ack,
    output waiting, halted, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, en_addr,
           sel_A, sel_B, mem_req, mem_we, mem_err
  );

  modport slave (
    output start, opcode, ALU_op, mem_ack,
    input  waiting, halted, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, en_addr,
           sel_A, sel_B, mem_req, mem_we, mem_err
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Moore FSM sequencing the register-file/ALU datapath, one instruction per start pulse,
// including LDR/STR memory access over a req/ack handshake, HALT and illegal-opcode handling.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : cpu_sequencer_if.master (decode inputs, datapath enables, memory handshake)
// Parameters:
//   HALT_ON_ILLEGAL : 1 illegal opcode halts, 0 it is ignored
//   MEM_TIMEOUT     : S_MEM cycle limit awaiting mem_ack (>= 2)
// Optional feature: define CPU_SEQ_TIMEOUT_EN to enable the S_MEM timeout and sticky mem_err.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned HALT_ON_ILLEGAL = 1,
  parameter int unsigned MEM_TIMEOUT     = 16
) (
  input logic             clk,
  input logic             rst_n,
  cpu_sequencer_if.master bus
);

  if (MEM_TIMEOUT < 2) begin : g_bad_timeout
    $error("MEM_TIMEOUT must be >= 2");
  end

  state_t state_q, state_d;
  instr_t instr_q, instr_d;
  logic   tmo_expired;
  logic   mem_err;

  // The instruction class is latched on acceptance so that EXEC/MEM outputs depend only on
  // registered state, not on whatever decode presents later.
  assign instr_d = (state_q == S_WAIT && bus.start) ? decode(bus.opcode, bus.ALU_op) : instr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      instr_q <= I_ILL;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

`ifdef CPU_SEQ_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(MEM_TIMEOUT + 1);

  logic [TmoW-1:0] tmo_q;
  logic            mem_err_q;

  // tmo_q counts completed S_MEM cycles; the current one is the last allowed when it equals
  // MEM_TIMEOUT-1. An ack in that cycle still completes normally.
  assign tmo_expired = (state_q == S_MEM) && !bus.mem_ack && (tmo_q == TmoW'(MEM_TIMEOUT - 1));
  assign mem_err     = mem_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      tmo_q     <= (state_q == S_MEM) ? tmo_q + TmoW'(1) : '0;
      mem_err_q <= mem_err_q | tmo_expired;
    end
  end
`else
  assign tmo_expired = 1'b0;
  assign mem_err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_WAIT: begin
        if (bus.start) begin
          unique case (instr_d)
            I_MOVI:                      state_d = S_MOVI;
            I_MOV, I_MVN:                state_d = S_LDB;
            I_ADD, I_AND, I_CMP,
            I_LDR, I_STR:                state_d = S_LDA;
            I_HALT:                      state_d = S_HALT;
            default: state_d = (HALT_ON_ILLEGAL != 0) ? S_HALT : S_WAIT;
          endcase
        end
      end
      S_MOVI: state_d = S_WAIT;
      S_LDA:  state_d = (instr_q == I_LDR || instr_q == I_STR) ? S_ADDR : S_LDB;
      S_LDB:  state_d = S_EXEC;
      S_EXEC: state_d = (instr_q == I_CMP) ? S_WAIT : S_WB;
      S_WB:   state_d = S_WAIT;
      S_ADDR: state_d = (instr_q == I_STR) ? S_SLDB : S_MEM;
      S_SLDB: state_d = S_SEXE;
      S_SEXE: state_d = S_MEM;
      S_MEM: begin
        if (bus.mem_ack)      state_d = (instr_q == I_LDR) ? S_LWB : S_WAIT;
        else if (tmo_expired) state_d = S_HALT;
      end
      S_LWB:  state_d = S_WAIT;
      S_HALT: state_d = S_HALT;
      default: state_d = S_WAIT;
    endcase
  end

  always_comb begin
    bus.waiting   = 1'b0;
    bus.halted    = 1'b0;
    bus.reg_sel   = REG_SEL_RM;
    bus.wb_sel    = WB_SEL_C;
    bus.w_en      = 1'b0;
    bus.en_A      = 1'b0;
    bus.en_B      = 1'b0;
    bus.en_C      = 1'b0;
    bus.en_status = 1'b0;
    bus.en_addr   = 1'b0;
    bus.sel_A     = 1'b0;
    bus.sel_B     = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_err   = mem_err;
    unique case (state_q)
      S_WAIT: bus.waiting = 1'b1;
      S_MOVI: begin
        bus.reg_sel = REG_SEL_RD;
        bus.wb_sel  = WB_SEL_IMM8;
        bus.w_en    = 1'b1;
      end
      S_LDA: begin
        bus.reg_sel = REG_SEL_RN;
        bus.en_A    = 1'b1;
      end
      S_LDB: begin
        bus.reg_sel = REG_SEL_RM;
        bus.en_B    = 1'b1;
      end
      S_EXEC: begin
        // CMP only updates status; MOV/MVN pass B through with A forced to 0.
        if (instr_q == I_CMP) begin
          bus.en_status = 1'b1;
        end else begin
          bus.en_C  = 1'b1;
          bus.sel_A = (instr_q == I_MOV || instr_q == I_MVN);
        end
      end
      S_WB: begin
        bus.reg_sel = REG_SEL_RD;
        bus.wb_sel  = WB_SEL_C;
        bus.w_en    = 1'b1;
      end
      S_ADDR: begin
        // C = Rn + sximm5, also captured as the memory address.
        bus.en_addr = 1'b1;
        bus.sel_B   = 1'b1;
        bus.en_C    = 1'b1;
      end
      S_SLDB: begin
        bus.reg_sel = REG_SEL_RD;
        bus.en_B    = 1'b1;
      end
      S_SEXE: begin
        bus.sel_A = 1'b1;
        bus.en_C  = 1'b1;
      end
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = (instr_q == I_STR);
      end
      S_LWB: begin
        bus.reg_sel = REG_SEL_RD;
        bus.wb_sel  = WB_SEL_MEM;
        bus.w_en    = 1'b1;
      end
      S_HALT: bus.halted = 1'b1;
      default: bus.waiting = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer. Output vector order:
// {waiting, halted, reg_sel[1:0], wb_sel[1:0], w_en, en_A, en_B, en_C, en_status, en_addr,
//  sel_A, sel_B, mem_req, mem_we, mem_err}
module tb_cpu_sequencer;

  localparam logic [16:0] O_WAIT  = 17'b1_0_00_00_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] O_MOVI  = 17'b0_0_01_10_1_0_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] O_LDA   = 17'b0_0_10_00_0_1_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] O_LDB   = 17'b0_0_00_00_0_0_1_0_0_0_0_0_0_0_0;
  localparam logic [16:0] O_EXEC  = 17'b0_0_00_00_0_0_0_1_0_0_0_0_0_0_0;
  localparam logic [16:0] O_EXMV  = 17'b0_0_00_00_0_0_0_1_0_0_1_0_0_0_0;
  localparam logic [16:0] O_EXCMP = 17'b0_0_00_00_0_0_0_0_1_0_0_0_0_0_0;
  localparam logic [16:0] O_WB    = 17'b0_0_01_00_1_0_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] O_ADDR  = 17'b0_0_00_00_0_0_0_1_0_1_0_1_0_0_0;
  localparam logic [16:0] O_SLDB  = 17'b0_0_01_00_0_0_1_0_0_0_0_0_0_0_0;
  localparam logic [16:0] O_SEXE  = 17'b0_0_00_00_0_0_0_1_0_0_1_0_0_0_0;
  localparam logic [16:0] O_MEMR  = 17'b0_0_00_00_0_0_0_0_0_0_0_0_1_0_0;
  localparam logic [16:0] O_MEMW  = 17'b0_0_00_00_0_0_0_0_0_0_0_0_1_1_0;
  localparam logic [16:0] O_LWB   = 17'b0_0_01_01_1_0_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] O_HALT  = 17'b0_1_00_00_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] O_HERR  = 17'b0_1_00_00_0_0_0_0_0_0_0_0_0_0_1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  cpu_sequencer_if bus ();

  cpu_sequencer #(
    .HALT_ON_ILLEGAL(1),
    .MEM_TIMEOUT    (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] outs();
    return {bus.waiting, bus.halted, bus.reg_sel, bus.wb_sel, bus.w_en, bus.en_A, bus.en_B,
            bus.en_C, bus.en_status, bus.en_addr, bus.sel_A, bus.sel_B, bus.mem_req,
            bus.mem_we, bus.mem_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] alu);
    bus.start  = 1'b1;
    bus.opcode = op;
    bus.ALU_op = alu;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (outs() !== O_WAIT) begin
      errors++;
      $display("FAIL reset_hold got %b want %b", outs(), O_WAIT);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (outs() !== O_WAIT) begin
      errors++;
      $display("FAIL reset_release got %b want %b", outs(), O_WAIT);
    end
  endtask

  task automatic test_reset_mid_mem();
    issue(3'b011, 2'b00);
    tick();
    tick();
    checks++;
    if (outs() !== O_MEMR) begin
      errors++;
      $display("FAIL rst_mem_pre got %b want %b", outs(), O_MEMR);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== O_WAIT) begin
      errors++;
      $display("FAIL rst_mem_async got %b want %b", outs(), O_WAIT);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (outs() !== O_WAIT) begin
      errors++;
      $display("FAIL rst_mem_after got %b want %b", outs(), O_WAIT);
    end
  endtask

  task automatic test_movi();
    logic [16:0] exp [2];
    exp = '{O_MOVI, O_WAIT};
    issue(3'b110, 2'b10);
    foreach (exp[i]) begin
      checks++;
      if (outs() !== exp[i]) begin
        errors++;
        $display("FAIL movi step %0d got %b want %b", i, outs(), exp[i]);
      end
      tick();
    end
  endtask

  // ADD with a MOVI start pulse during LDB that must be ignored.
  task automatic test_add_ignore_start();
    logic [16:0] exp [5];
    exp = '{O_LDA, O_LDB, O_EXEC, O_WB, O_WAIT};
    issue(3'b101, 2'b00);
    foreach (exp[i]) begin
      if (i == 2) begin
        bus.start  = 1'b0;
        bus.opcode = 3'b101;
        bus.ALU_op = 2'b00;
      end
      checks++;
      if (outs() !== exp[i]) begin
        errors++;
        $display("FAIL add step %0d got %b want %b", i, outs(), exp[i]);
      end
      if (i == 1) begin
        bus.start  = 1'b1;
        bus.opcode = 3'b110;
        bus.ALU_op = 2'b10;
      end
      tick();
    end
  endtask

  task automatic test_cmp();
    logic [16:0] exp [4];
    exp = '{O_LDA, O_LDB, O_EXCMP, O_WAIT};
    issue(3'b101, 2'b01);
    foreach (exp[i]) begin
      checks++;
      if (outs() !== exp[i]) begin
        errors++;
        $display("FAIL cmp step %0d got %b want %b", i, outs(), exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_mvn_mov_and();
    logic [16:0] exp3 [4];
    logic [16:0] exp4 [5];
    exp3 = '{O_LDB, O_EXMV, O_WB, O_WAIT};
    issue(3'b101, 2'b11);
    foreach (exp3[i]) begin
      checks++;
      if (outs() !== exp3[i]) begin
        errors++;
        $display("FAIL mvn step %0d got %b want %b", i, outs(), exp3[i]);
      end
      tick();
    end
    issue(3'b110, 2'b00);
    foreach (exp3[i]) begin
      checks++;
      if (outs() !== exp3[i]) begin
        errors++;
        $display("FAIL mov step %0d got %b want %b", i, outs(), exp3[i]);
      end
      tick();
    end
    exp4 = '{O_LDA, O_LDB, O_EXEC, O_WB, O_WAIT};
    issue(3'b101, 2'b10);
    foreach (exp4[i]) begin
      checks++;
      if (outs() !== exp4[i]) begin
        errors++;
        $display("FAIL and step %0d got %b want %b", i, outs(), exp4[i]);
      end
      tick();
    end
  endtask

  task automatic test_ldr();
    logic [16:0] exp [7];
    exp = '{O_LDA, O_ADDR, O_MEMR, O_MEMR, O_MEMR, O_LWB, O_WAIT};
    issue(3'b011, 2'b00);
    foreach (exp[i]) begin
      if (i == 4) bus.mem_ack = 1'b1;
      if (i == 5) bus.mem_ack = 1'b0;
      checks++;
      if (outs() !== exp[i]) begin
        errors++;
        $display("FAIL ldr step %0d got %b want %b", i, outs(), exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_str();
    logic [16:0] exp [6];
    exp = '{O_LDA, O_ADDR, O_SLDB, O_SEXE, O_MEMW, O_WAIT};
    issue(3'b100, 2'b00);
    foreach (exp[i]) begin
      if (i == 4) bus.mem_ack = 1'b1;
      if (i == 5) bus.mem_ack = 1'b0;
      checks++;
      if (outs() !== exp[i]) begin
        errors++;
        $display("FAIL str step %0d got %b want %b", i, outs(), exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_halt();
    issue(3'b111, 2'b01);
    bus.opcode = 3'b110;
    bus.ALU_op = 2'b10;
    bus.start  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (outs() !== O_HALT) begin
        errors++;
        $display("FAIL halt cycle %0d got %b want %b", i, outs(), O_HALT);
      end
      tick();
    end
    bus.start = 1'b0;
    do_reset();
    checks++;
    if (outs() !== O_WAIT) begin
      errors++;
      $display("FAIL halt_reset got %b want %b", outs(), O_WAIT);
    end
  endtask

  task automatic test_illegal();
    issue(3'b000, 2'b00);
    checks++;
    if (outs() !== O_HALT) begin
      errors++;
      $display("FAIL illegal_000 got %b want %b", outs(), O_HALT);
    end
    do_reset();
    issue(3'b110, 2'b01);
    checks++;
    if (outs() !== O_HALT) begin
      errors++;
      $display("FAIL illegal_110_01 got %b want %b", outs(), O_HALT);
    end
    do_reset();
  endtask

`ifdef CPU_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    logic [16:0] exp  [8];
    logic [16:0] exp2 [8];
    exp = '{O_LDA, O_ADDR, O_MEMR, O_MEMR, O_MEMR, O_MEMR, O_HERR, O_HERR};
    issue(3'b011, 2'b00);
    foreach (exp[i]) begin
      if (i == 6) bus.start = 1'b1;
      checks++;
      if (outs() !== exp[i]) begin
        errors++;
        $display("FAIL timeout step %0d got %b want %b", i, outs(), exp[i]);
      end
      tick();
    end
    bus.start = 1'b0;
    do_reset();
    checks++;
    if (outs() !== O_WAIT) begin
      errors++;
      $display("FAIL timeout_reset got %b want %b", outs(), O_WAIT);
    end
    // Ack on the last allowed S_MEM cycle completes normally.
    exp2 = '{O_LDA, O_ADDR, O_MEMR, O_MEMR, O_MEMR, O_MEMR, O_LWB, O_WAIT};
    issue(3'b011, 2'b00);
    foreach (exp2[i]) begin
      if (i == 5) bus.mem_ack = 1'b1;
      if (i == 6) bus.mem_ack = 1'b0;
      checks++;
      if (outs() !== exp2[i]) begin
        errors++;
        $display("FAIL late_ack step %0d got %b want %b", i, outs(), exp2[i]);
      end
      tick();
    end
  endtask
`else
  task automatic test_mem_wait();
    logic [16:0] exp [16];
    exp[0] = O_LDA;
    exp[1] = O_ADDR;
    for (int k = 2; k < 14; k++) exp[k] = O_MEMR;
    exp[14] = O_LWB;
    exp[15] = O_WAIT;
    issue(3'b011, 2'b00);
    foreach (exp[i]) begin
      if (i == 13) bus.mem_ack = 1'b1;
      if (i == 14) bus.mem_ack = 1'b0;
      checks++;
      if (outs() !== exp[i]) begin
        errors++;
        $display("FAIL mem_wait step %0d got %b want %b", i, outs(), exp[i]);
      end
      tick();
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.opcode  = 3'b000;
    bus.ALU_op  = 2'b00;
    bus.mem_ack = 1'b0;
    test_reset();
    test_movi();
    test_add_ignore_start();
    test_cmp();
    test_mvn_mov_and();
    test_ldr();
    test_str();
    test_reset_mid_mem();
    test_halt();
    test_illegal();
`ifdef CPU_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_mem_wait();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
